fetch_unit: RTL and testbench

- Instruction fetch stage and sole producer of the ifid_t bundle consumed by the IF/ID pipeline register.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel.
- Pairs in-order responses with their PCs and buffers them in a small fetch queue.
- Presents one ifid_t per cycle to decode.
- Handles redirects (branch/jump/trap) by discarding wrong-path responses still in flight.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the IF/ID bundle and the fetch FSM state encoding.
package pipeline_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: redirect input, imem request/response channel and decode-side handshake.
interface fetch_unit_if
    import pipeline_pkg::*;
#(
    parameter int XLEN = PC_W
) ();
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    ifid_t             ifid_out;
    logic              ifid_valid;
    logic              ifid_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, ifid_ready,
        output imem_req_valid, imem_req_addr, ifid_out, ifid_valid
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, ifid_ready,
        input  imem_req_valid, imem_req_addr, ifid_out, ifid_valid
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous clear; storage is not reset, only the pointers/count.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests, fetch queue to decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and pulse fetch_misaligned.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int              XLEN     = PC_W,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic fetch_misaligned
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] pend_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   q_count;
    logic [CW:0]     credit_used;
    ifid_t           q_entry, q_head;
    logic            req_fire, rsp, q_push, q_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_target = bus.redirect_pc;
`else
    assign redir_target = {bus.redirect_pc[XLEN-1:2], bus.redirect_pc[1:0] & 2'b00};
`endif

    assign req_fire    = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp         = bus.imem_rsp_valid;
    // A redirect wins over everything in the same cycle: no enqueue, no dequeue.
    assign q_push      = rsp && (drop == '0) && !bus.redirect_valid;
    assign q_pop       = bus.ifid_valid && bus.ifid_ready && !bus.redirect_valid;
    assign credit_used = {1'b0, outstanding} + {1'b0, q_count};

    assign q_entry.pc       = pend_pc;
    assign q_entry.pc_plus4 = pend_pc + XLEN'(4);
    assign q_entry.instr    = bus.imem_rsp_data;

    // The pending-PC occupancy is exactly the number of requests still awaiting a response.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_pend_fifo (
        .clk(clk), .reset(reset), .clear(1'b0),
        .push(req_fire), .push_data(pc), .pop(rsp),
        .head(pend_pc), .count(outstanding)
    );

    fetch_fifo #(.WIDTH($bits(ifid_t)), .DEPTH(FQ_DEPTH)) u_fetch_q (
        .clk(clk), .reset(reset), .clear(bus.redirect_valid),
        .push(q_push), .push_data(q_entry), .pop(q_pop),
        .head(q_head), .count(q_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (bus.redirect_valid)
            state_nxt = (bus.redirect_pc[1:0] != 2'b00) ? HALT : RUN;
`else
        if (state == HALT) state_nxt = RUN;
`endif
    end

    always_comb begin
        bus.imem_req_valid = (state == RUN) && !bus.redirect_valid &&
                             (credit_used < (CW+1)'(FQ_DEPTH));
        bus.imem_req_addr  = pc;
        bus.ifid_valid     = (q_count != '0);
        bus.ifid_out       = bus.ifid_valid ? q_head : '0;
    end

    // Every response in flight at a redirect belongs to the wrong path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else if (bus.redirect_valid) begin
            pc   <= redir_target;
            drop <= outstanding - CW'(rsp);
        end else begin
            if (req_fire)              pc   <= pc + XLEN'(4);
            if (rsp && (drop != '0))   drop <= drop - CW'(1);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetch_misaligned <= 1'b0;
        else       fetch_misaligned <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with an in-order variable-latency memory model.
module tb_fetch_unit;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();
`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_misaligned;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] sb[$];
    logic [31:0] exp_fetch_pc;
    int checks = 0, errors = 0;
    int cyc = 0, latency = 1, ready_mode = 0, ifid_pct = 100;
    int nfire = 0, naccept = 0, nmis = 0;
    bit halted = 1'b0;
    bit redir_req = 1'b0, redir_on_rsp = 1'b0;
    logic [31:0] redir_req_pc = '0, redir_on_rsp_pc = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_ctl();
        case (ready_mode)
            0:       bus.imem_req_ready = 1'b1;
            1:       bus.imem_req_ready = cyc[0];
            default: bus.imem_req_ready = ($urandom_range(99) < 75);
        endcase
        bus.ifid_ready = ($urandom_range(99) < ifid_pct);
    endtask

    task automatic step();
        mreq_t r;
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            r = memq.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(r.addr);
        end
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        if (redir_req) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_req_pc;
            redir_req          = 1'b0;
        end else if (redir_on_rsp && bus.imem_rsp_valid) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_on_rsp_pc;
            redir_on_rsp       = 1'b0;
        end
        drive_ctl();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        memq.delete();
        sb.delete();
        exp_fetch_pc = 32'h0;
        halted = 1'b0;
        redir_req = 1'b0;
        redir_on_rsp = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_ifid_valid", 32'(bus.ifid_valid), 32'd0);
        chk("rst_ifid_out_zero", 32'(|bus.ifid_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        drive_ctl();
        nfire = 0;
        naccept = 0;
        nmis = 0;
        @(negedge clk);
        chk("boot_no_req", 32'(bus.imem_req_valid), 32'd0);
    endtask

    // Monitor: predicts the fetch address stream and the decode stream from redirects alone.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset === 1'b0) begin
            chk("outstanding_bound", 32'(memq.size() <= 4), 32'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (fetch_misaligned) nmis++;
`endif
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_addr", bus.imem_req_addr, exp_fetch_pc);
                chk("halt_no_req", 32'(halted), 32'd0);
                memq.push_back('{addr: bus.imem_req_addr, due: cyc + latency});
                sb.push_back(exp_fetch_pc);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                nfire++;
            end
            if (bus.ifid_valid && bus.ifid_ready && !bus.redirect_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ifid_unexpected: got pc %h, expected no valid output", bus.ifid_out.pc);
                end else begin
                    e = sb.pop_front();
                    chk("ifid_pc", bus.ifid_out.pc, e);
                    chk("ifid_pc_plus4", bus.ifid_out.pc_plus4, e + 32'd4);
                    chk("ifid_instr", bus.ifid_out.instr, instr_of(e));
                    naccept++;
                end
            end
            if (bus.redirect_valid) begin
                sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                exp_fetch_pc = bus.redirect_pc;
                halted = (bus.redirect_pc[1:0] != 2'b00);
`else
                exp_fetch_pc = bus.redirect_pc & 32'hFFFF_FFFC;
                halted = 1'b0;
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.ifid_ready     = 1'b0;

        // Back-to-back fetch with a 1-cycle memory.
        latency = 1; ready_mode = 0; ifid_pct = 100;
        do_reset();
        step(); @(negedge clk);
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        step(); @(negedge clk);
        chk("second_req_addr", bus.imem_req_addr, 32'h4);
        chk("no_bypass_valid", 32'(bus.ifid_valid), 32'd0);
        step(); @(negedge clk);
        chk("third_req_addr", bus.imem_req_addr, 32'h8);
        chk("first_ifid_valid", 32'(bus.ifid_valid), 32'd1);
        chk("first_ifid_pc", bus.ifid_out.pc, 32'h0);
        chk("first_ifid_pc_plus4", bus.ifid_out.pc_plus4, 32'h4);
        repeat (20) step();

        // Decode stalled: credits cap the requests, then drain in order.
        ifid_pct = 0;
        do_reset();
        repeat (10) step();
        @(negedge clk);
        chk("stall_fire_count", nfire, 32'd4);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        ifid_pct = 100;
        repeat (30) step();
        chk("drain_accepts", 32'(naccept >= 8), 32'd1);

        // Redirect with requests in flight on a 3-cycle memory.
        latency = 3;
        do_reset();
        repeat (8) step();
        redir_req = 1'b1; redir_req_pc = 32'h100;
        step();
        step(); @(negedge clk);
        chk("redir_plus1_valid", 32'(bus.ifid_valid), 32'd0);
        naccept = 0;
        repeat (20) step();
        chk("after_redir_accepts", 32'(naccept > 0), 32'd1);

        // Redirect coinciding with a response.
        redir_on_rsp = 1'b1; redir_on_rsp_pc = 32'h200;
        for (int i = 0; i < 20 && redir_on_rsp; i++) step();
        chk("redir_on_rsp_seen", 32'(redir_on_rsp), 32'd0);
        naccept = 0;
        repeat (20) step();
        chk("after_rsp_redir_accepts", 32'(naccept > 0), 32'd1);

        // Toggling request ready with 3-cycle latency.
        ready_mode = 1; ifid_pct = 70;
        do_reset();
        for (int i = 0; i < 3000 && naccept < 50; i++) step();
        chk("toggle_accepts_50", 32'(naccept >= 50), 32'd1);

        // Random ready/decode stalls and random redirects, including wrap-around targets.
        latency = 2; ready_mode = 2; ifid_pct = 60;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4) begin
                t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + ($urandom & 32'hF))
                                             : ($urandom & 32'h0000_FFFF);
`ifdef FETCH_MISALIGN_CHECK_EN
                t = t & 32'hFFFF_FFFC;
`endif
                redir_req = 1'b1; redir_req_pc = t;
            end
            step();
        end
        chk("random_accepts", 32'(naccept > 50), 32'd1);

        // Misaligned redirect target.
        latency = 1; ready_mode = 0; ifid_pct = 100;
        do_reset();
        repeat (5) step();
        redir_req = 1'b1; redir_req_pc = 32'h102;
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        repeat (10) step();
        @(negedge clk);
        chk("misalign_pulses", nmis, 32'd1);
        chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
        redir_req = 1'b1; redir_req_pc = 32'h104;
        step();
`endif
        naccept = 0;
        repeat (15) step();
        chk("post_misalign_accepts", 32'(naccept > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
